// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin arbiter sharing one memory-mapped I/O bus between two requesters.
// Rev 1.0 - initial release.
`default_nettype none

module io_bus_arbiter #(
  parameter int DBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [1:0]         we,
  input  logic [2*DBITS-1:0] addr,
  input  logic [2*DBITS-1:0] wdata,
  output logic [1:0]         ack,
  output logic [DBITS-1:0]   rdata,
  output logic               busy,
  output logic               ld,
  output logic               sw,
  output logic [DBITS-1:0]   addrbus,
  inout  wire  [DBITS-1:0]   databus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_gnt;
  logic             gnt;
  logic             gnt_nxt;
  logic             cap_we;
  logic [DBITS-1:0] cap_addr;
  logic [DBITS-1:0] cap_wdata;
  logic             capture;
  logic             drive_bus;

  // The port that did not win last time gets priority; otherwise the lone requester wins.
  always_comb begin
    gnt_nxt = req[~last_gnt] ? ~last_gnt : last_gnt;
    capture = (state == IDLE) && (|req);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = XFER;
      XFER:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt  <= 1'b1;
      gnt       <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      ack       <= 2'b00;
      rdata     <= '0;
    end else begin
      ack <= 2'b00;
      if (capture) begin
        gnt       <= gnt_nxt;
        last_gnt  <= gnt_nxt;
        cap_we    <= we[gnt_nxt];
        cap_addr  <= gnt_nxt ? addr[2*DBITS-1:DBITS]  : addr[DBITS-1:0];
        cap_wdata <= gnt_nxt ? wdata[2*DBITS-1:DBITS] : wdata[DBITS-1:0];
      end
      if (state == XFER) begin
        ack <= gnt ? 2'b10 : 2'b01;
        if (!cap_we) rdata <= databus;
      end
    end
  end

  // Bus signals decode only from state and captured registers.
  assign drive_bus = (state == XFER) && cap_we;
  assign busy      = (state != IDLE);
  assign ld        = (state == XFER) && !cap_we;
  assign sw        = drive_bus;
  assign addrbus   = (state == XFER) ? cap_addr : '0;
  assign databus   = drive_bus ? cap_wdata : 'z;

endmodule

`default_nettype wire
